// File: rtl/uart_cmd_mem_ctrl.sv
// ASCII command parser: 'p' frame write, 'r' frame read (hex reply over UART TX), 'P' register write.
// Define CMD_TIMEOUT_EN to abort partial commands after TIMEOUT_CYCLES without an accepted byte.
module uart_cmd_mem_ctrl #(
    parameter int ADDR_WIDTH      = 17,
    parameter int DATA_WIDTH      = 12,
    parameter int DEPTH           = 76800,
    parameter int ADDR_DIGITS     = 5,
    parameter int DATA_DIGITS     = 3,
    parameter int REG_ADDR_WIDTH  = 7,
    parameter int REG_DATA_WIDTH  = 25,
    parameter int REG_ADDR_DIGITS = 2,
    parameter int REG_DATA_DIGITS = 7,
    parameter int TIMEOUT_CYCLES  = 1000000
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      i_enable,
    input  logic                      i_rx_dv,
    input  logic [7:0]                i_rx_byte,
    input  logic                      i_tx_done,
    output logic                      o_tx_dv,
    output logic [7:0]                o_tx_byte,
    output logic [ADDR_WIDTH-1:0]     o_addr_wr,
    output logic [DATA_WIDTH-1:0]     o_data_wr,
    output logic                      o_we,
    output logic [ADDR_WIDTH-1:0]     o_addr_rd,
    output logic                      o_re,
    input  logic [DATA_WIDTH-1:0]     i_data_rd,
    output logic [REG_ADDR_WIDTH-1:0] o_addr_wr_reg,
    output logic [REG_DATA_WIDTH-1:0] o_data_reg,
    output logic                      o_we_reg,
    output logic [3:0]                o_state,
    output logic                      o_err
);

    localparam logic [3:0] S_IDLE   = 4'd0;
    localparam logic [3:0] S_W_ADDR = 4'd1;
    localparam logic [3:0] S_W_DATA = 4'd2;
    localparam logic [3:0] S_W_MEM  = 4'd3;
    localparam logic [3:0] S_R_ADDR = 4'd4;
    localparam logic [3:0] S_R_MEM  = 4'd5;
    localparam logic [3:0] S_R_WAIT = 4'd6;
    localparam logic [3:0] S_TX_HEX = 4'd7;
    localparam logic [3:0] S_TX_EOL = 4'd8;
    localparam logic [3:0] S_G_ADDR = 4'd9;
    localparam logic [3:0] S_G_DATA = 4'd10;
    localparam logic [3:0] S_G_MEM  = 4'd11;
    localparam logic [3:0] S_ERR    = 4'd12;

    localparam int CNT_W = 4;
    localparam int HEX_W = 4 * DATA_DIGITS;
    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
    localparam logic [CNT_W-1:0] LAST_ADDR  = CNT_W'(ADDR_DIGITS - 1);
    localparam logic [CNT_W-1:0] LAST_DATA  = CNT_W'(DATA_DIGITS - 1);
    localparam logic [CNT_W-1:0] LAST_GADDR = CNT_W'(REG_ADDR_DIGITS - 1);
    localparam logic [CNT_W-1:0] LAST_GDATA = CNT_W'(REG_DATA_DIGITS - 1);

    function automatic logic is_dec(input logic [7:0] b);
        return (b >= 8'h30) && (b <= 8'h39);
    endfunction

    function automatic logic is_hex(input logic [7:0] b);
        return is_dec(b) || ((b >= 8'h61) && (b <= 8'h66)) || ((b >= 8'h41) && (b <= 8'h46));
    endfunction

    // Letters 'a'/'A' have low nibble 1, so +9 maps them onto 10..15.
    function automatic logic [3:0] hex_val(input logic [7:0] b);
        return is_dec(b) ? b[3:0] : b[3:0] + 4'd9;
    endfunction

    function automatic logic [7:0] hex_chr(input logic [3:0] n);
        return (n < 4'd10) ? {4'h3, n} : 8'h57 + {4'h0, n};
    endfunction

    logic [3:0]                state_q, state_d;
    logic [CNT_W-1:0]          cnt_q, cnt_d;
    logic [ADDR_WIDTH-1:0]     addr_acc_q, addr_acc_d;
    logic [DATA_WIDTH-1:0]     data_acc_q, data_acc_d;
    logic [REG_ADDR_WIDTH-1:0] gaddr_acc_q, gaddr_acc_d;
    logic [REG_DATA_WIDTH-1:0] gdata_acc_q, gdata_acc_d;
    logic [HEX_W-1:0]          tx_sh_q, tx_sh_d;
    logic                      tx_busy_q, tx_busy_d;
    logic                      tx_dv_q, tx_dv_d;
    logic [7:0]                tx_byte_q, tx_byte_d;
    logic [ADDR_WIDTH-1:0]     addr_wr_q, addr_wr_d;
    logic [DATA_WIDTH-1:0]     data_wr_q, data_wr_d;
    logic                      we_q, we_d;
    logic [ADDR_WIDTH-1:0]     addr_rd_q, addr_rd_d;
    logic                      re_q, re_d;
    logic [REG_ADDR_WIDTH-1:0] addr_wr_reg_q, addr_wr_reg_d;
    logic [REG_DATA_WIDTH-1:0] data_reg_q, data_reg_d;
    logic                      we_reg_q, we_reg_d;
    logic                      err_q, err_d;

    logic       rx_ok;
    logic [3:0] nib;
    logic       dec_ok, hex_ok;
    logic [31:0] addr_ext;
    logic       addr_ok;

    assign rx_ok    = i_rx_dv & i_enable;
    assign nib      = hex_val(i_rx_byte);
    assign dec_ok   = is_dec(i_rx_byte);
    assign hex_ok   = is_hex(i_rx_byte);
    assign addr_ext = 32'(addr_acc_q);
    assign addr_ok  = addr_ext < DEPTH;

`ifdef CMD_TIMEOUT_EN
    logic [31:0] to_cnt_q, to_cnt_d;
    logic        in_field;
    assign in_field = (state_q == S_W_ADDR) || (state_q == S_W_DATA) || (state_q == S_R_ADDR) ||
                      (state_q == S_G_ADDR) || (state_q == S_G_DATA);
`else
    localparam int TIMEOUT_UNUSED = TIMEOUT_CYCLES;
`endif

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        addr_acc_d    = addr_acc_q;
        data_acc_d    = data_acc_q;
        gaddr_acc_d   = gaddr_acc_q;
        gdata_acc_d   = gdata_acc_q;
        tx_sh_d       = tx_sh_q;
        tx_busy_d     = tx_busy_q;
        tx_byte_d     = tx_byte_q;
        addr_wr_d     = addr_wr_q;
        data_wr_d     = data_wr_q;
        addr_rd_d     = addr_rd_q;
        addr_wr_reg_d = addr_wr_reg_q;
        data_reg_d    = data_reg_q;
        tx_dv_d       = 1'b0;
        we_d          = 1'b0;
        re_d          = 1'b0;
        we_reg_d      = 1'b0;
        err_d         = 1'b0;
`ifdef CMD_TIMEOUT_EN
        to_cnt_d      = to_cnt_q;
`endif
        if (i_enable) begin
            case (state_q)
                S_IDLE: if (rx_ok) begin
                    cnt_d       = '0;
                    addr_acc_d  = '0;
                    data_acc_d  = '0;
                    gaddr_acc_d = '0;
                    gdata_acc_d = '0;
                    case (i_rx_byte)
                        8'h70:   state_d = S_W_ADDR;
                        8'h72:   state_d = S_R_ADDR;
                        8'h50:   state_d = S_G_ADDR;
                        default: state_d = S_IDLE;
                    endcase
                end
                S_W_ADDR, S_R_ADDR: if (rx_ok) begin
                    if (dec_ok) begin
                        addr_acc_d = addr_acc_q * ADDR_WIDTH'(10) + ADDR_WIDTH'(nib);
                        if (cnt_q == LAST_ADDR) begin
                            cnt_d   = '0;
                            state_d = (state_q == S_W_ADDR) ? S_W_DATA : S_R_MEM;
                        end else begin
                            cnt_d = cnt_q + CNT_ONE;
                        end
                    end else begin
                        state_d = S_ERR;
                    end
                end
                S_W_DATA: if (rx_ok) begin
                    if (hex_ok) begin
                        data_acc_d = DATA_WIDTH'({data_acc_q, nib});
                        if (cnt_q == LAST_DATA) begin
                            cnt_d   = '0;
                            state_d = S_W_MEM;
                        end else begin
                            cnt_d = cnt_q + CNT_ONE;
                        end
                    end else begin
                        state_d = S_ERR;
                    end
                end
                S_W_MEM: begin
                    if (addr_ok) begin
                        we_d      = 1'b1;
                        addr_wr_d = addr_acc_q;
                        data_wr_d = data_acc_q;
                        state_d   = S_IDLE;
                    end else begin
                        state_d = S_ERR;
                    end
                end
                S_R_MEM: begin
                    if (addr_ok) begin
                        re_d      = 1'b1;
                        addr_rd_d = addr_acc_q;
                        cnt_d     = '0;
                        state_d   = S_R_WAIT;
                    end else begin
                        state_d = S_ERR;
                    end
                end
                // o_re is registered, so read data lands two cycles after R_MEM.
                S_R_WAIT: begin
                    if (cnt_q == '0) begin
                        cnt_d = CNT_ONE;
                    end else begin
                        tx_sh_d   = HEX_W'(i_data_rd);
                        tx_busy_d = 1'b0;
                        cnt_d     = '0;
                        state_d   = S_TX_HEX;
                    end
                end
                S_TX_HEX: begin
                    if (!tx_busy_q) begin
                        tx_dv_d   = 1'b1;
                        tx_byte_d = hex_chr(tx_sh_q[HEX_W-1 -: 4]);
                        tx_sh_d   = tx_sh_q << 4;
                        tx_busy_d = 1'b1;
                    end else if (i_tx_done) begin
                        tx_busy_d = 1'b0;
                        if (cnt_q == LAST_DATA) begin
                            cnt_d   = '0;
                            state_d = S_TX_EOL;
                        end else begin
                            cnt_d = cnt_q + CNT_ONE;
                        end
                    end
                end
                S_TX_EOL: begin
                    if (!tx_busy_q) begin
                        tx_dv_d   = 1'b1;
                        tx_byte_d = 8'h0A;
                        tx_busy_d = 1'b1;
                    end else if (i_tx_done) begin
                        tx_busy_d = 1'b0;
                        state_d   = S_IDLE;
                    end
                end
                S_G_ADDR: if (rx_ok) begin
                    if (hex_ok) begin
                        gaddr_acc_d = REG_ADDR_WIDTH'({gaddr_acc_q, nib});
                        if (cnt_q == LAST_GADDR) begin
                            cnt_d   = '0;
                            state_d = S_G_DATA;
                        end else begin
                            cnt_d = cnt_q + CNT_ONE;
                        end
                    end else begin
                        state_d = S_ERR;
                    end
                end
                S_G_DATA: if (rx_ok) begin
                    if (hex_ok) begin
                        gdata_acc_d = REG_DATA_WIDTH'({gdata_acc_q, nib});
                        if (cnt_q == LAST_GDATA) begin
                            cnt_d   = '0;
                            state_d = S_G_MEM;
                        end else begin
                            cnt_d = cnt_q + CNT_ONE;
                        end
                    end else begin
                        state_d = S_ERR;
                    end
                end
                S_G_MEM: begin
                    we_reg_d      = 1'b1;
                    addr_wr_reg_d = gaddr_acc_q;
                    data_reg_d    = gdata_acc_q;
                    state_d       = S_IDLE;
                end
                S_ERR: begin
                    err_d   = 1'b1;
                    state_d = S_IDLE;
                end
                default: state_d = S_IDLE;
            endcase
`ifdef CMD_TIMEOUT_EN
            to_cnt_d = '0;
            if (in_field && !rx_ok) begin
                to_cnt_d = to_cnt_q + 32'd1;
                if (to_cnt_d == 32'(TIMEOUT_CYCLES)) begin
                    to_cnt_d = '0;
                    state_d  = S_ERR;
                end
            end
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= S_IDLE;
            cnt_q         <= '0;
            addr_acc_q    <= '0;
            data_acc_q    <= '0;
            gaddr_acc_q   <= '0;
            gdata_acc_q   <= '0;
            tx_sh_q       <= '0;
            tx_busy_q     <= 1'b0;
            tx_dv_q       <= 1'b0;
            tx_byte_q     <= '0;
            addr_wr_q     <= '0;
            data_wr_q     <= '0;
            we_q          <= 1'b0;
            addr_rd_q     <= '0;
            re_q          <= 1'b0;
            addr_wr_reg_q <= '0;
            data_reg_q    <= '0;
            we_reg_q      <= 1'b0;
            err_q         <= 1'b0;
`ifdef CMD_TIMEOUT_EN
            to_cnt_q      <= '0;
`endif
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            addr_acc_q    <= addr_acc_d;
            data_acc_q    <= data_acc_d;
            gaddr_acc_q   <= gaddr_acc_d;
            gdata_acc_q   <= gdata_acc_d;
            tx_sh_q       <= tx_sh_d;
            tx_busy_q     <= tx_busy_d;
            tx_dv_q       <= tx_dv_d;
            tx_byte_q     <= tx_byte_d;
            addr_wr_q     <= addr_wr_d;
            data_wr_q     <= data_wr_d;
            we_q          <= we_d;
            addr_rd_q     <= addr_rd_d;
            re_q          <= re_d;
            addr_wr_reg_q <= addr_wr_reg_d;
            data_reg_q    <= data_reg_d;
            we_reg_q      <= we_reg_d;
            err_q         <= err_d;
`ifdef CMD_TIMEOUT_EN
            to_cnt_q      <= to_cnt_d;
`endif
        end
    end

    assign o_state       = state_q;
    assign o_tx_dv       = tx_dv_q;
    assign o_tx_byte     = tx_byte_q;
    assign o_addr_wr     = addr_wr_q;
    assign o_data_wr     = data_wr_q;
    assign o_we          = we_q;
    assign o_addr_rd     = addr_rd_q;
    assign o_re          = re_q;
    assign o_addr_wr_reg = addr_wr_reg_q;
    assign o_data_reg    = data_reg_q;
    assign o_we_reg      = we_reg_q;
    assign o_err         = err_q;

endmodule

// File: tb/tb_uart_cmd_mem_ctrl.sv
// Directed bench for uart_cmd_mem_ctrl: command table plus hand sequences for enable, reset and timeout.
module tb_uart_cmd_mem_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        i_enable = 1'b0;
    logic        i_rx_dv = 1'b0;
    logic [7:0]  i_rx_byte = 8'h00;
    logic        i_tx_done = 1'b0;
    logic [11:0] i_data_rd = 12'h000;
    logic [11:0] rd_val = 12'h000;

    logic        o_tx_dv;
    logic [7:0]  o_tx_byte;
    logic [16:0] o_addr_wr;
    logic [11:0] o_data_wr;
    logic        o_we;
    logic [16:0] o_addr_rd;
    logic        o_re;
    logic [6:0]  o_addr_wr_reg;
    logic [24:0] o_data_reg;
    logic        o_we_reg;
    logic [3:0]  o_state;
    logic        o_err;

    uart_cmd_mem_ctrl #(.TIMEOUT_CYCLES(100)) dut (
        .clk(clk), .rst(rst), .i_enable(i_enable), .i_rx_dv(i_rx_dv), .i_rx_byte(i_rx_byte),
        .i_tx_done(i_tx_done), .o_tx_dv(o_tx_dv), .o_tx_byte(o_tx_byte),
        .o_addr_wr(o_addr_wr), .o_data_wr(o_data_wr), .o_we(o_we),
        .o_addr_rd(o_addr_rd), .o_re(o_re), .i_data_rd(i_data_rd),
        .o_addr_wr_reg(o_addr_wr_reg), .o_data_reg(o_data_reg), .o_we_reg(o_we_reg),
        .o_state(o_state), .o_err(o_err)
    );

    always #5 clk = ~clk;

    // Frame buffer model: one-cycle read latency.
    always @(posedge clk) if (o_re) i_data_rd <= rd_val;

    // UART TX model: done strobe 20 cycles after each start strobe.
    initial begin
        forever begin
            @(negedge clk);
            if (o_tx_dv) begin
                repeat (20) @(negedge clk);
                i_tx_done = 1'b1;
                @(negedge clk);
                i_tx_done = 1'b0;
            end
        end
    end

    int          we_n = 0, re_n = 0, wreg_n = 0, err_n = 0, tx_n = 0;
    logic [16:0] we_addr_at = '0;
    logic [11:0] we_data_at = '0;
    logic [7:0]  tx_log [0:255];

    always @(negedge clk) begin
        if (o_we) begin
            we_n       <= we_n + 1;
            we_addr_at <= o_addr_wr;
            we_data_at <= o_data_wr;
        end
        if (o_re) re_n <= re_n + 1;
        if (o_we_reg) wreg_n <= wreg_n + 1;
        if (o_err) err_n <= err_n + 1;
        if (o_tx_dv) begin
            tx_log[tx_n[7:0]] <= o_tx_byte;
            tx_n              <= tx_n + 1;
        end
    end

    int n_vec = 0, n_bad = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        @(negedge clk);
        i_rx_dv   = 1'b1;
        i_rx_byte = b;
        @(negedge clk);
        i_rx_dv   = 1'b0;
    endtask

    task automatic send_str(input string s);
        for (int k = 0; k < s.len(); k++) send_byte(s[k]);
    endtask

    typedef struct {
        logic [95:0] cmd;
        int          len;
        logic [11:0] rd;
        int          we, re, wreg, err, ntx;
        logic [31:0] txb;
        logic [16:0] aw;
        logic [11:0] dw;
        logic [16:0] ar;
        logic [6:0]  ga;
        logic [24:0] gd;
    } vec_t;

    localparam int NV = 12;
    vec_t vt [NV];

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int b_we, b_re, b_wreg, b_err, b_tx;

        // Expected address/data columns are the held output values after each command.
        vt[0]  = '{"p000120ab",  9, 12'h000, 1, 0, 0, 0, 0, 32'h0,        17'd12,    12'h0ab, 17'd0,     7'h00, 25'h0000000};
        vt[1]  = '{"r00012",     6, 12'h0ab, 0, 1, 0, 0, 4, 32'h3061620a, 17'd12,    12'h0ab, 17'd12,    7'h00, 25'h0000000};
        vt[2]  = '{"P1f0123abc", 10, 12'h000, 0, 0, 1, 0, 0, 32'h0,       17'd12,    12'h0ab, 17'd12,    7'h1f, 25'h0123abc};
        vt[3]  = '{"p00g",       4, 12'h000, 0, 0, 0, 1, 0, 32'h0,        17'd12,    12'h0ab, 17'd12,    7'h1f, 25'h0123abc};
        vt[4]  = '{"p00001001",  9, 12'h000, 1, 0, 0, 0, 0, 32'h0,        17'd1,     12'h001, 17'd12,    7'h1f, 25'h0123abc};
        vt[5]  = '{"p99999fff",  9, 12'h000, 0, 0, 0, 1, 0, 32'h0,        17'd1,     12'h001, 17'd12,    7'h1f, 25'h0123abc};
        vt[6]  = '{"p76799FFF",  9, 12'h000, 1, 0, 0, 0, 0, 32'h0,        17'd76799, 12'hfff, 17'd12,    7'h1f, 25'h0123abc};
        vt[7]  = '{"r76800",     6, 12'h000, 0, 0, 0, 1, 0, 32'h0,        17'd76799, 12'hfff, 17'd12,    7'h1f, 25'h0123abc};
        vt[8]  = '{"r00005",     6, 12'hc3e, 0, 1, 0, 0, 4, 32'h6333650a, 17'd76799, 12'hfff, 17'd5,     7'h1f, 25'h0123abc};
        vt[9]  = '{"xyz",        3, 12'h000, 0, 0, 0, 0, 0, 32'h0,        17'd76799, 12'hfff, 17'd5,     7'h1f, 25'h0123abc};
        vt[10] = '{"Pzz",        3, 12'h000, 0, 0, 0, 1, 0, 32'h0,        17'd76799, 12'hfff, 17'd5,     7'h1f, 25'h0123abc};
        vt[11] = '{"P7ffffffff", 10, 12'h000, 0, 0, 1, 0, 0, 32'h0,       17'd76799, 12'hfff, 17'd5,     7'h7f, 25'h1ffffff};

        rst      = 1'b1;
        i_enable = 1'b1;
        repeat (4) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("reset state", 32'(o_state), 32'd0);
        chk("reset strobes", 32'({o_we, o_re, o_we_reg, o_err, o_tx_dv}), 32'd0);
        chk("reset tx_byte", 32'(o_tx_byte), 32'd0);
        chk("reset addr_wr", 32'(o_addr_wr), 32'd0);
        chk("reset data_reg", 32'(o_data_reg), 32'd0);

        for (int v = 0; v < NV; v++) begin
            b_we = we_n; b_re = re_n; b_wreg = wreg_n; b_err = err_n; b_tx = tx_n;
            rd_val = vt[v].rd;
            for (int k = 0; k < vt[v].len; k++) send_byte(vt[v].cmd[(vt[v].len-1-k)*8 +: 8]);
            if (vt[v].ntx > 0) begin
                for (int w = 0; w < 500 && tx_n < b_tx + vt[v].ntx; w++) @(negedge clk);
                repeat (25) @(negedge clk);
            end else begin
                repeat (8) @(negedge clk);
            end
            chk($sformatf("v%0d we pulses", v), 32'(we_n - b_we), 32'(vt[v].we));
            chk($sformatf("v%0d re pulses", v), 32'(re_n - b_re), 32'(vt[v].re));
            chk($sformatf("v%0d we_reg pulses", v), 32'(wreg_n - b_wreg), 32'(vt[v].wreg));
            chk($sformatf("v%0d err pulses", v), 32'(err_n - b_err), 32'(vt[v].err));
            chk($sformatf("v%0d tx count", v), 32'(tx_n - b_tx), 32'(vt[v].ntx));
            if (vt[v].we > 0) begin
                chk($sformatf("v%0d addr at we", v), 32'(we_addr_at), 32'(vt[v].aw));
                chk($sformatf("v%0d data at we", v), 32'(we_data_at), 32'(vt[v].dw));
            end
            for (int i = 0; i < vt[v].ntx && i < 4; i++)
                chk($sformatf("v%0d tx byte %0d", v, i), 32'(tx_log[8'(b_tx + i)]), 32'(vt[v].txb[31-8*i -: 8]));
            chk($sformatf("v%0d state", v), 32'(o_state), 32'd0);
            chk($sformatf("v%0d addr_wr", v), 32'(o_addr_wr), 32'(vt[v].aw));
            chk($sformatf("v%0d data_wr", v), 32'(o_data_wr), 32'(vt[v].dw));
            chk($sformatf("v%0d addr_rd", v), 32'(o_addr_rd), 32'(vt[v].ar));
            chk($sformatf("v%0d addr_wr_reg", v), 32'(o_addr_wr_reg), 32'(vt[v].ga));
            chk($sformatf("v%0d data_reg", v), 32'(o_data_reg), 32'(vt[v].gd));
        end

        // Bytes offered while disabled are dropped.
        b_we = we_n;
        i_enable = 1'b0;
        send_str("p000010ab");
        i_enable = 1'b1;
        repeat (5) @(negedge clk);
        chk("disabled no write", 32'(we_n - b_we), 32'd0);
        chk("disabled state", 32'(o_state), 32'd0);

        // FSM freezes mid-command; dropped digit does not count.
        send_str("p00");
        i_enable = 1'b0;
        repeat (10) @(negedge clk);
        chk("frozen state", 32'(o_state), 32'd1);
        send_str("9");
        i_enable = 1'b1;
        send_str("007abc");
        repeat (8) @(negedge clk);
        chk("frozen resume we", 32'(we_n - b_we), 32'd1);
        chk("frozen resume addr", 32'(o_addr_wr), 32'd7);
        chk("frozen resume data", 32'(o_data_wr), 32'habc);

        // Reset while the hex reply is in flight.
        rd_val = 12'h0ab;
        b_tx = tx_n;
        send_str("r00012");
        for (int w = 0; w < 200 && tx_n == b_tx; w++) @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (150) @(negedge clk);
        chk("rst mid-tx count", 32'(tx_n - b_tx), 32'd1);
        chk("rst mid-tx state", 32'(o_state), 32'd0);
        chk("rst mid-tx addr_rd", 32'(o_addr_rd), 32'd0);

        // Partial command left idle.
        b_err = err_n;
        send_str("p12");
        repeat (110) @(negedge clk);
`ifdef CMD_TIMEOUT_EN
        chk("timeout err", 32'(err_n - b_err), 32'd1);
        chk("timeout state", 32'(o_state), 32'd0);
`else
        chk("no-timeout err", 32'(err_n - b_err), 32'd0);
        chk("no-timeout state", 32'(o_state), 32'd1);
`endif

        // Reset mid-command: the remaining bytes must not complete a write.
        b_we = we_n;
        send_str("p00003");
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        send_str("0ab");
        repeat (8) @(negedge clk);
        chk("rst mid-cmd no write", 32'(we_n - b_we), 32'd0);
        chk("rst mid-cmd state", 32'(o_state), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
